gray_counter: RTL and testbench
===============================

// Module: gray_counter
// PURPOSE
//  Parametrised up/down counter that maintains a binary count and its registered
//  Gray-code image in lockstep. It supports synchronous load, hold,
//  and a wrap or saturate end-of-range mode.
//  Intended as the pointer source for async-FIFO/CDC paths. gray_out is a flop
//  output, is glitch-free, and changes at most one bit per enabled step.
// PARAMETERS
//  WIDTH      4  count width in bits; legal range >= 2
//  RESET_VAL  0  binary value loaded on reset; must be < 2**WIDTH
//  WRAP_MODE  1  1 = wrap at the range ends; 0 = saturate at the range ends
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-high
//  en        in   1      step enable; one step per cycle while high
//  up_dn     in   1      step direction: 1 = increment, 0 = decrement
//  load      in   1      synchronous load of load_bin
//  load_bin  in   WIDTH  binary value to load
//  bin_out   out  WIDTH  registered binary count
//  gray_out  out  WIDTH  registered Gray code of bin_out: bin ^ (bin >> 1)
//  tc        out  1      one-cycle pulse: an enabled step was taken from an end value
// BEHAVIOUR
//  - Command priority, sampled on each rising clk edge: rst > load > en > hold.
//  - Reset values: bin_out = RESET_VAL, gray_out = gray(RESET_VAL), tc = 0.
//  - All three outputs update on the same edge and come straight from flops.
//    gray_out is computed from the next binary value and then registered.
//    It is never decoded combinationally from bin_out.
//  - Latency is 1 cycle: a command applied in cycle N is visible on the outputs
//    in cycle N+1. gray_out always equals gray(bin_out) in every cycle.
//  - load = 1: bin_out <= load_bin and tc <= 0. en and up_dn are ignored.
//  - en = 1, up_dn = 1:
//      bin_out < MAX  -> bin_out + 1, tc = 0
//      bin_out == MAX, WRAP_MODE = 1 -> bin_out <= 0, tc = 1
//      bin_out == MAX, WRAP_MODE = 0 -> bin_out holds, tc = 1
//    MAX = 2**WIDTH - 1.
//  - en = 1, up_dn = 0:
//      bin_out > 0  -> bin_out - 1, tc = 0
//      bin_out == 0, WRAP_MODE = 1 -> bin_out <= MAX, tc = 1
//      bin_out == 0, WRAP_MODE = 0 -> bin_out holds, tc = 1
//  - en = 0 with no load: all outputs hold, and tc <= 0.
//  - In saturate mode, tc re-asserts on every cycle that another step into the
//    end value is attempted.
//  - up_dn may change on any cycle, including back-to-back reversals. The count
//    is always exactly one step from the previous value, with no lost steps.
//  - Arithmetic is modulo 2**WIDTH. No carry or borrow leaves the block.
//  - rst asserted mid-count overrides load and en in that cycle.
//    Counting resumes from RESET_VAL on the first cycle after rst deasserts.
//  - Single-bit change: with no load and no rst, successive gray_out values
//    differ in at most 1 bit, including across the wrap. Load and reset are
//    exempt from this rule.
// TESTING  (WIDTH = 4, RESET_VAL = 0 unless noted)
//  1. rst held for 2 cycles, en = 1 -> bin_out = 0, gray_out = 0, tc = 0 during
//     and after reset.
//  2. WRAP_MODE = 1, en = 1, up_dn = 1 for 17 cycles from 0 ->
//     gray_out = 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8,0.
//     tc pulses for exactly the cycle in which bin_out becomes 0 (after 15).
//     Every transition flips exactly 1 bit.
//  3. WRAP_MODE = 1, from 0, en = 1, up_dn = 0 ->
//     bin_out = 15, gray_out = 8, tc = 1. The next step gives bin_out = 14,
//     gray_out = 9, tc = 0.
//  4. WRAP_MODE = 0, count up to 15, then 3 more enabled up cycles ->
//     bin_out stays 15, gray_out stays 8, tc = 1 for all 3 cycles.
//     Then up_dn = 0 -> bin_out = 14, tc = 0.
//  5. load = 1, load_bin = 5, en = 1 in the same cycle -> bin_out = 5,
//     gray_out = 7, tc = 0.
//     Same cycle with rst = 1 instead -> bin_out = 0 (RESET_VAL).
//  6. en = 0 for 4 cycles at bin_out = 9 -> bin_out = 9, gray_out = D held,
//     tc = 0.
//     Then alternate up_dn each cycle with en = 1 -> 10, 9, 10, 9, with no
//     skipped values.

Source files
------------

// File: rtl/gray_counter_if.sv
// Bus bundle for the Gray-code pointer counter.
//   en, up_dn       : step enable and direction (1 = up)
//   load, load_bin  : synchronous load of a binary value
//   bin_out         : registered binary count
//   gray_out        : registered Gray image of bin_out
//   tc              : one-cycle end-of-range step pulse
// master drives the commands, slave is the counter itself.
interface gray_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] bin_out;
  logic [WIDTH-1:0] gray_out;
  logic             tc;

  modport master (
    output en, up_dn, load, load_bin,
    input  bin_out, gray_out, tc
  );

  modport slave (
    input  en, up_dn, load, load_bin,
    output bin_out, gray_out, tc
  );
endinterface

// File: rtl/gray_counter.sv
// Up/down counter keeping a binary count and its Gray-code image in lockstep,
// intended as an async-FIFO / CDC pointer source. All outputs are flops; the
// Gray value is computed from the next binary value and registered, so it is
// glitch-free and moves by at most one bit per enabled step.
//   clk  : rising-edge clock
//   rst  : synchronous reset, active-high
//   bus  : gray_counter_if.slave (commands in, bin_out/gray_out/tc out)
// Command priority per edge: rst > load > en > hold.
module gray_counter #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               WRAP_MODE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  gray_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX        = '1;
  localparam logic [WIDTH-1:0] RESET_GRAY = RESET_VAL ^ (RESET_VAL >> 1);

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q,   tc_d;

  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (bus.load) begin
      bin_d = bus.load_bin;
    end else if (bus.en) begin
      if (bus.up_dn) begin
        if (bin_q == MAX) begin
          tc_d  = 1'b1;
          bin_d = WRAP_MODE ? '0 : bin_q;
        end else begin
          bin_d = bin_q + WIDTH'(1);
        end
      end else begin
        if (bin_q == '0) begin
          tc_d  = 1'b1;
          bin_d = WRAP_MODE ? MAX : bin_q;
        end else begin
          bin_d = bin_q - WIDTH'(1);
        end
      end
    end
    // Encode from the next binary value so gray_q never lags bin_q.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= RESET_VAL;
      gray_q <= RESET_GRAY;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign bus.bin_out  = bin_q;
  assign bus.gray_out = gray_q;
  assign bus.tc       = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
module tb_gray_counter;

  typedef struct packed {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // wa: WRAP_MODE = 1, sb: WRAP_MODE = 0, same stimulus on both.
  gray_counter_if #(.WIDTH(4)) ifa ();
  gray_counter_if #(.WIDTH(4)) ifb ();

  gray_counter #(.WIDTH(4), .RESET_VAL(4'd0), .WRAP_MODE(1'b1)) dut_wa (
    .clk(clk), .rst(rst), .bus(ifa.slave)
  );
  gray_counter #(.WIDTH(4), .RESET_VAL(4'd0), .WRAP_MODE(1'b0)) dut_sb (
    .clk(clk), .rst(rst), .bus(ifb.slave)
  );

  exp_t q_wa[$];
  exp_t q_sb[$];
  exp_t m_wa, m_sb;
  logic [3:0] prev_gray_wa, prev_gray_sb;

  function automatic exp_t model(input exp_t cur, input bit wrap, input logic r,
                                 input logic l, input logic [3:0] lb,
                                 input logic e, input logic ud);
    exp_t n;
    n.bin = cur.bin;
    n.tc  = 1'b0;
    if (r) begin
      n.bin = 4'd0;
    end else if (l) begin
      n.bin = lb;
    end else if (e && ud) begin
      if (cur.bin == 4'd15) begin
        n.tc = 1'b1;
        if (wrap) n.bin = 4'd0;
      end else n.bin = cur.bin + 4'd1;
    end else if (e && !ud) begin
      if (cur.bin == 4'd0) begin
        n.tc = 1'b1;
        if (wrap) n.bin = 4'd15;
      end else n.bin = cur.bin - 4'd1;
    end
    n.gray = n.bin ^ (n.bin >> 1);
    return n;
  endfunction

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic l, input logic [3:0] lb,
                      input logic e, input logic ud);
    exp_t ea, eb;
    rst = r;
    ifa.load = l; ifa.load_bin = lb; ifa.en = e; ifa.up_dn = ud;
    ifb.load = l; ifb.load_bin = lb; ifb.en = e; ifb.up_dn = ud;
    m_wa = model(m_wa, 1'b1, r, l, lb, e, ud);
    m_sb = model(m_sb, 1'b0, r, l, lb, e, ud);
    q_wa.push_back(m_wa);
    q_sb.push_back(m_sb);
    @(posedge clk);
    #1;
    ea = q_wa.pop_front();
    eb = q_sb.pop_front();
    chk4("wa_bin",  ifa.bin_out,  ea.bin);
    chk4("wa_gray", ifa.gray_out, ea.gray);
    chk1("wa_tc",   ifa.tc,       ea.tc);
    chk4("sb_bin",  ifb.bin_out,  eb.bin);
    chk4("sb_gray", ifb.gray_out, eb.gray);
    chk1("sb_tc",   ifb.tc,       eb.tc);
    if (!r && !l) begin
      checks++;
      assert ($countones(ifa.gray_out ^ prev_gray_wa) <= 1) else begin
        failures++;
        $error("FAIL wa_onebit observed=%h->%h expected=at most 1 bit change",
               prev_gray_wa, ifa.gray_out);
      end
      checks++;
      assert ($countones(ifb.gray_out ^ prev_gray_sb) <= 1) else begin
        failures++;
        $error("FAIL sb_onebit observed=%h->%h expected=at most 1 bit change",
               prev_gray_sb, ifb.gray_out);
      end
    end
    prev_gray_wa = ifa.gray_out;
    prev_gray_sb = ifb.gray_out;
  endtask

  logic [3:0] gray_seq [17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  initial begin
    m_wa = '0;
    m_sb = '0;
    prev_gray_wa = '0;
    prev_gray_sb = '0;

    // Reset held two cycles with en high.
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    chk4("rst_bin_c1", ifa.bin_out, 4'd0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    chk4("rst_gray_c2", ifa.gray_out, 4'd0);
    chk1("rst_tc_c2", ifa.tc, 1'b0);

    // Up count across the wrap, checked against the literal Gray table.
    chk4("seq_gray_0", ifa.gray_out, gray_seq[0]);
    for (int i = 1; i < 17; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      chk4("seq_gray", ifa.gray_out, gray_seq[i]);
      chk1("seq_tc", ifa.tc, (i == 16));
    end

    // Down step from 0 in wrap mode.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk4("dn_wrap_bin", ifa.bin_out, 4'd15);
    chk4("dn_wrap_gray", ifa.gray_out, 4'h8);
    chk1("dn_wrap_tc", ifa.tc, 1'b1);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk4("dn_next_bin", ifa.bin_out, 4'd14);
    chk4("dn_next_gray", ifa.gray_out, 4'h9);
    chk1("dn_next_tc", ifa.tc, 1'b0);

    // Saturate mode: up to 15, then three more attempts.
    step(1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    chk4("sat_reach_bin", ifb.bin_out, 4'd15);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
      chk4("sat_hold_bin", ifb.bin_out, 4'd15);
      chk4("sat_hold_gray", ifb.gray_out, 4'h8);
      chk1("sat_hold_tc", ifb.tc, 1'b1);
    end
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk4("sat_down_bin", ifb.bin_out, 4'd14);
    chk1("sat_down_tc", ifb.tc, 1'b0);

    // Load beats en; rst beats load.
    step(1'b0, 1'b1, 4'd5, 1'b1, 1'b1);
    chk4("load_bin", ifa.bin_out, 4'd5);
    chk4("load_gray", ifa.gray_out, 4'h7);
    chk1("load_tc", ifa.tc, 1'b0);
    step(1'b1, 1'b1, 4'd5, 1'b1, 1'b1);
    chk4("rst_over_load", ifa.bin_out, 4'd0);

    // Hold at 9, then back-to-back reversals.
    step(1'b0, 1'b1, 4'd9, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
      chk4("hold_bin", ifa.bin_out, 4'd9);
      chk4("hold_gray", ifa.gray_out, 4'hD);
      chk1("hold_tc", ifa.tc, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 4'd0, 1'b1, (i % 2 == 0));
      chk4("alt_bin", ifa.bin_out, (i % 2 == 0) ? 4'd10 : 4'd9);
    end

    // Load into the saturate boundary at 0, then attempt down steps.
    step(1'b0, 1'b1, 4'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    chk4("sat0_bin", ifb.bin_out, 4'd0);
    chk1("sat0_tc", ifb.tc, 1'b1);

    // Random mix, model-checked through the scoreboard.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
